// File: rtl/instruction_cache_if.sv
// Fetch-side and L2-side signal bundle for instruction_cache.
// slave = cache side, master = fetch stage plus L2 side.
interface instruction_cache_if #(
    parameter int unsigned ADDRESS_WIDTH       = 32,
    parameter int unsigned WORD_WIDTH          = 32,
    parameter int unsigned BLOCK_WIDTH         = 512,
    parameter int unsigned BLOCK_ADDRESS_WIDTH = 26
);
    logic                           STALL_INSTRUCTION_CACHE;
    logic [ADDRESS_WIDTH-1:0]       PC;
    logic                           PC_VALID;
    logic [WORD_WIDTH-1:0]          INSTRUCTION;
    logic                           INSTRUCTION_CACHE_READY;
    logic                           ADDRESS_TO_L2_READY_INSTRUCTION_CACHE;
    logic                           ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE;
    logic [BLOCK_ADDRESS_WIDTH-1:0] ADDRESS_TO_L2_INSTRUCTION_CACHE;
    logic                           DATA_FROM_L2_READY_INSTRUCTION_CACHE;
    logic                           DATA_FROM_L2_VALID_INSTRUCTION_CACHE;
    logic [BLOCK_WIDTH-1:0]         DATA_FROM_L2_INSTRUCTION_CACHE;

    modport slave (
        input  STALL_INSTRUCTION_CACHE, PC, PC_VALID,
               ADDRESS_TO_L2_READY_INSTRUCTION_CACHE,
               DATA_FROM_L2_VALID_INSTRUCTION_CACHE, DATA_FROM_L2_INSTRUCTION_CACHE,
        output INSTRUCTION, INSTRUCTION_CACHE_READY,
               ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE, ADDRESS_TO_L2_INSTRUCTION_CACHE,
               DATA_FROM_L2_READY_INSTRUCTION_CACHE
    );

    modport master (
        output STALL_INSTRUCTION_CACHE, PC, PC_VALID,
               ADDRESS_TO_L2_READY_INSTRUCTION_CACHE,
               DATA_FROM_L2_VALID_INSTRUCTION_CACHE, DATA_FROM_L2_INSTRUCTION_CACHE,
        input  INSTRUCTION, INSTRUCTION_CACHE_READY,
               ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE, ADDRESS_TO_L2_INSTRUCTION_CACHE,
               DATA_FROM_L2_READY_INSTRUCTION_CACHE
    );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped, read-only L1 instruction cache with whole-block refill from L2.
// Define ICACHE_PERF_CNT_EN to add HIT_COUNT / MISS_COUNT lookup counters.
module instruction_cache #(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned WORD_SIZE      = 4,
    parameter int unsigned WORD_PER_BLOCK = 16,
    parameter int unsigned CACHE_LINES    = 64
) (
    input  logic                CLK,
    input  logic                RST_N,
    instruction_cache_if.slave  bus
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]         HIT_COUNT,
    output logic [31:0]         MISS_COUNT
`endif
);
    localparam int unsigned WordW    = 8 * WORD_SIZE;
    localparam int unsigned BlockW   = WordW * WORD_PER_BLOCK;
    localparam int unsigned ByteOffW = $clog2(WORD_SIZE);
    localparam int unsigned WordSelW = $clog2(WORD_PER_BLOCK);
    localparam int unsigned OffW     = ByteOffW + WordSelW;
    localparam int unsigned IdxW     = $clog2(CACHE_LINES);
    localparam int unsigned TagW     = ADDRESS_WIDTH - OffW - IdxW;
    localparam int unsigned BlkAddrW = ADDRESS_WIDTH - OffW;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [CACHE_LINES-1:0] valid_q, valid_d;
    logic [BlkAddrW-1:0]    miss_addr_q, miss_addr_d;
    logic [WordW-1:0]       instr_q, instr_d;
    logic                   ready_q, ready_d;

    logic [TagW-1:0]        tag_q  [CACHE_LINES];
    logic [BlockW-1:0]      line_q [CACHE_LINES];

    logic [IdxW-1:0]     pc_idx;
    logic [TagW-1:0]     pc_tag;
    logic [WordSelW-1:0] pc_word;
    logic [BlockW-1:0]   line_rd;
    logic [WordW-1:0]    hit_word;
    logic                hit, lookup, fill;
    logic [IdxW-1:0]     fill_idx;
    logic [TagW-1:0]     fill_tag;

    assign pc_idx   = bus.PC[OffW +: IdxW];
    assign pc_tag   = bus.PC[ADDRESS_WIDTH-1 -: TagW];
    assign pc_word  = bus.PC[ByteOffW +: WordSelW];
    assign line_rd  = line_q[pc_idx];
    assign hit      = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign lookup   = (state_q == IDLE) && !bus.STALL_INSTRUCTION_CACHE && bus.PC_VALID;
    // Data arriving in REQ together with the address handshake is taken like WAIT data.
    assign fill     = ((state_q == REQ) || (state_q == WAIT))
                      && bus.DATA_FROM_L2_VALID_INSTRUCTION_CACHE;
    assign fill_idx = miss_addr_q[IdxW-1:0];
    assign fill_tag = miss_addr_q[BlkAddrW-1 -: TagW];

    // Word 0 sits in the most significant slice of the block.
    always_comb begin
        hit_word = '0;
        for (int j = 0; j < WORD_PER_BLOCK; j++) begin
            if (pc_word == j[WordSelW-1:0]) begin
                hit_word = line_rd[BlockW-1-WordW*j -: WordW];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        miss_addr_d = miss_addr_q;
        instr_d     = instr_q;
        ready_d     = ready_q;
        case (state_q)
            IDLE: begin
                if (lookup) begin
                    if (hit) begin
                        instr_d = hit_word;
                        ready_d = 1'b1;
                    end else begin
                        ready_d     = 1'b0;
                        miss_addr_d = bus.PC[ADDRESS_WIDTH-1 -: BlkAddrW];
                        state_d     = REQ;
                    end
                end else if (!bus.STALL_INSTRUCTION_CACHE) begin
                    ready_d = 1'b0;
                end
            end
            REQ: begin
                ready_d = 1'b0;
                if (fill) begin
                    valid_d[fill_idx] = 1'b1;
                    state_d           = IDLE;
                end else if (bus.ADDRESS_TO_L2_READY_INSTRUCTION_CACHE) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                ready_d = 1'b0;
                if (fill) begin
                    valid_d[fill_idx] = 1'b1;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            miss_addr_q <= '0;
            instr_q     <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            miss_addr_q <= miss_addr_d;
            instr_q     <= instr_d;
            ready_q     <= ready_d;
        end
    end

    // Storage arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_q[fill_idx]  <= fill_tag;
            line_q[fill_idx] <= bus.DATA_FROM_L2_INSTRUCTION_CACHE;
        end
    end

    assign bus.INSTRUCTION                           = instr_q;
    assign bus.INSTRUCTION_CACHE_READY               = ready_q;
    assign bus.ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE = (state_q == REQ);
    assign bus.ADDRESS_TO_L2_INSTRUCTION_CACHE       = miss_addr_q;
    assign bus.DATA_FROM_L2_READY_INSTRUCTION_CACHE  = (state_q == REQ) || (state_q == WAIT);

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (lookup && hit)  hit_cnt_d  = hit_cnt_q + 32'd1;
        if (lookup && !hit) miss_cnt_d = miss_cnt_q + 32'd1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign HIT_COUNT  = hit_cnt_q;
    assign MISS_COUNT = miss_cnt_q;
`endif
endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: directed cases then random fetches
// against a line-index/tag reference model and a 1-cycle L2 responder.
module tb_instruction_cache;
    localparam int MemWords = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    instruction_cache_if bus ();

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_count, miss_count;
`endif

    instruction_cache dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .HIT_COUNT  (hit_count),
        .MISS_COUNT (miss_count)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] mem [MemWords];
    bit          model_valid [64];
    logic [19:0] model_tag   [64];
    logic [31:0] last_instr;
    int          checks = 0;
    int          errors = 0;
    int unsigned exp_hits = 0;
    int unsigned exp_misses = 0;

    function automatic logic [511:0] block_of(input logic [25:0] baddr);
        logic [511:0] blk;
        for (int j = 0; j < 16; j++) begin
            blk[511-32*j -: 32] = mem[(16 * int'(baddr) + j) % MemWords];
        end
        return blk;
    endfunction

    // L2: one cycle after the address handshake, present the block until taken.
    logic        hs_a, hs_d;
    logic [25:0] req_addr;
    initial begin
        bus.DATA_FROM_L2_VALID_INSTRUCTION_CACHE = 1'b0;
        bus.DATA_FROM_L2_INSTRUCTION_CACHE       = '0;
        forever begin
            @(posedge clk);
            hs_a = bus.ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE
                   && bus.ADDRESS_TO_L2_READY_INSTRUCTION_CACHE
                   && bus.DATA_FROM_L2_READY_INSTRUCTION_CACHE;
            hs_d = bus.DATA_FROM_L2_VALID_INSTRUCTION_CACHE
                   && bus.DATA_FROM_L2_READY_INSTRUCTION_CACHE;
            req_addr = bus.ADDRESS_TO_L2_INSTRUCTION_CACHE;
            #1;
            if (hs_d || !rst_n) bus.DATA_FROM_L2_VALID_INSTRUCTION_CACHE = 1'b0;
            if (hs_a && rst_n) begin
                bus.DATA_FROM_L2_INSTRUCTION_CACHE       = block_of(req_addr);
                bus.DATA_FROM_L2_VALID_INSTRUCTION_CACHE = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_refill(input logic [31:0] pc, input int exp_lat, input string tag);
        int n;
        int idx;
        n   = 0;
        idx = int'((pc >> 6) % 64);
        while (!bus.INSTRUCTION_CACHE_READY && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_fill_rdy"}, 32'(bus.INSTRUCTION_CACHE_READY), 32'd1);
        check({tag, "_fill_ins"}, bus.INSTRUCTION, mem[(pc >> 2) % MemWords]);
        if (bus.INSTRUCTION_CACHE_READY) exp_hits++;
        model_valid[idx] = 1'b1;
        model_tag[idx]   = pc[31:12];
        last_instr       = mem[(pc >> 2) % MemWords];
    endtask

    // exp_lat < 0: caller drives the refill wait itself.
    task automatic fetch(input logic [31:0] pc, input int exp_lat, input string tag);
        int idx;
        bit hit;
        idx = int'((pc >> 6) % 64);
        hit = model_valid[idx] && (model_tag[idx] == pc[31:12]);
        bus.PC                      = pc;
        bus.PC_VALID                = 1'b1;
        bus.STALL_INSTRUCTION_CACHE = 1'b0;
        tick();
        if (hit) begin
            exp_hits++;
            last_instr = mem[(pc >> 2) % MemWords];
            check({tag, "_hit_rdy"}, 32'(bus.INSTRUCTION_CACHE_READY), 32'd1);
            check({tag, "_hit_ins"}, bus.INSTRUCTION, last_instr);
            check({tag, "_hit_noreq"}, 32'(bus.ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE), 32'd0);
        end else begin
            exp_misses++;
            check({tag, "_miss_rdy"}, 32'(bus.INSTRUCTION_CACHE_READY), 32'd0);
            check({tag, "_miss_req"}, 32'(bus.ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE), 32'd1);
            check({tag, "_miss_addr"}, 32'(bus.ADDRESS_TO_L2_INSTRUCTION_CACHE), pc >> 6);
            if (exp_lat >= 0) wait_refill(pc, exp_lat, tag);
        end
    endtask

    initial begin
        logic [31:0] pc;
        for (int i = 0; i < MemWords; i++) mem[i] = $urandom;
        for (int i = 0; i < 64; i++) model_valid[i] = 1'b0;
        bus.STALL_INSTRUCTION_CACHE               = 1'b0;
        bus.PC                                    = '0;
        bus.PC_VALID                              = 1'b0;
        bus.ADDRESS_TO_L2_READY_INSTRUCTION_CACHE = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_rdy", 32'(bus.INSTRUCTION_CACHE_READY), 32'd0);
        check("rst_ins", bus.INSTRUCTION, 32'd0);
        check("rst_req", 32'(bus.ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE), 32'd0);
        check("rst_addr", 32'(bus.ADDRESS_TO_L2_INSTRUCTION_CACHE), 32'd0);
        check("rst_dready", 32'(bus.DATA_FROM_L2_READY_INSTRUCTION_CACHE), 32'd0);
        rst_n = 1'b1;
        tick();

        // Cold miss, then hits within the same block
        fetch(32'd8, 3, "cold");
        fetch(32'd0, 3, "h0");
        fetch(32'd12, 3, "h12");
        fetch(32'd4, 3, "h4");
        fetch(32'd0, 3, "h0b");
        fetch(32'd16, 3, "h16");
        fetch(32'd20, 3, "h20");
        // Same index, new tag evicts; old block misses again
        fetch(32'h1000, 3, "conflict");
        fetch(32'd4, 3, "remiss");

        // Stall freezes outputs while PC moves
        fetch(32'h20, 3, "pre_stall");
        bus.STALL_INSTRUCTION_CACHE = 1'b1;
        bus.PC = 32'h24;
        tick();
        check("stall_ins", bus.INSTRUCTION, mem[8]);
        check("stall_rdy", 32'(bus.INSTRUCTION_CACHE_READY), 32'd1);
        bus.PC = 32'h28;
        tick();
        check("stall2_ins", bus.INSTRUCTION, mem[8]);
        bus.STALL_INSTRUCTION_CACHE = 1'b0;
        bus.PC = 32'h24;
        tick();
        exp_hits++;
        check("unstall_ins", bus.INSTRUCTION, mem[9]);
        check("unstall_rdy", 32'(bus.INSTRUCTION_CACHE_READY), 32'd1);
        bus.PC_VALID = 1'b0;
        tick();
        check("novalid_rdy", 32'(bus.INSTRUCTION_CACHE_READY), 32'd0);
        check("novalid_ins", bus.INSTRUCTION, mem[9]);

        // L2 back-pressure in REQ
        bus.ADDRESS_TO_L2_READY_INSTRUCTION_CACHE = 1'b0;
        fetch(32'h3084, -1, "bp");
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_req", 32'(bus.ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE), 32'd1);
            check("bp_addr", 32'(bus.ADDRESS_TO_L2_INSTRUCTION_CACHE), 32'h3084 >> 6);
            check("bp_rdy", 32'(bus.INSTRUCTION_CACHE_READY), 32'd0);
        end
        bus.ADDRESS_TO_L2_READY_INSTRUCTION_CACHE = 1'b1;
        wait_refill(32'h3084, 3, "bp");

        // Reset mid-refill abandons it and invalidates every line
        bus.ADDRESS_TO_L2_READY_INSTRUCTION_CACHE = 1'b0;
        fetch(32'h20c0, -1, "rstmid");
        tick();
        rst_n = 1'b0;
        #1;
        check("rstmid_req", 32'(bus.ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE), 32'd0);
        check("rstmid_addr", 32'(bus.ADDRESS_TO_L2_INSTRUCTION_CACHE), 32'd0);
        for (int i = 0; i < 64; i++) model_valid[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        tick();
        rst_n = 1'b1;
        bus.ADDRESS_TO_L2_READY_INSTRUCTION_CACHE = 1'b1;
        fetch(32'h20c0, 3, "post_rst");
        fetch(32'h24, 3, "post_rst_old");

        // Random fetches with occasional idle cycles
        for (int it = 0; it < 150; it++) begin
            pc = $urandom_range(0, 16383);
            fetch(pc, 3, "rnd");
            if ($urandom_range(0, 3) == 0) begin
                bus.PC_VALID = 1'b0;
                tick();
                check("rnd_idle_rdy", 32'(bus.INSTRUCTION_CACHE_READY), 32'd0);
                check("rnd_idle_ins", bus.INSTRUCTION, last_instr);
            end
        end

`ifdef ICACHE_PERF_CNT_EN
        check("perf_hits", hit_count, exp_hits);
        check("perf_misses", miss_count, exp_misses);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
